// File: rtl/sb_pkg.sv
// Shared constants for the scoreboard hazard unit.
// Also holds the result-latency clamp used when a producer is issued.
package sb_pkg;

   localparam int NREG     = 32;
   localparam int AW       = 5;
   localparam int MAX_LAT  = 4;
   localparam int LW       = 3;
   localparam int LAT_ALU  = 1;
   localparam int LAT_LOAD = 2;
   localparam int LAT_MUL  = 4;

   // A zero latency is treated as one cycle, and latencies above max_lat are capped,
   // so the value written into a counter always fits the counter.
   function automatic int clamp_lat(input int lat, input int max_lat);
      if (lat == 0) begin
         return 1;
      end
      if (lat > max_lat) begin
         return max_lat;
      end
      return lat;
   endfunction

endpackage

// File: rtl/sb_reg_counter.sv
// Per-register pending counter for the scoreboard.
// A load takes priority over the decrement, and the counter stops at zero instead of wrapping.
module sb_reg_counter #(
   parameter int LW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [LW-1:0] load_val,
   output logic [LW-1:0] cnt,
   output logic          nz
);

   logic [LW-1:0] cnt_d;
   logic [LW-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign nz  = (cnt_q != '0);

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Decode-stage hazard detector built from one down-counter per architectural register.
// It detects read-after-write and write-after-write hazards and keeps a saturating count of stall cycles.
module scoreboard_hazard_unit #(
   parameter int NREG    = sb_pkg::NREG,
   parameter int AW      = sb_pkg::AW,
   parameter int MAX_LAT = sb_pkg::MAX_LAT,
   parameter int LW      = sb_pkg::LW,
   parameter int SW      = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rs,
   input  logic [AW-1:0]   issue_rt,
   input  logic            use_rs,
   input  logic            use_rt,
   input  logic            issue_we,
   input  logic [AW-1:0]   issue_rd,
   input  logic [LW-1:0]   issue_lat,
   input  logic            kill,
   output logic            stall,
   output logic            rs_wait,
   output logic            rt_wait,
   output logic            waw_wait,
   output logic [NREG-1:0] busy,
   output logic [SW-1:0]   stall_cycles
);

   import sb_pkg::*;

   logic [LW-1:0] cnt [NREG];
   logic [LW-1:0] lat_eff;
   logic [LW-1:0] lat_m1;
   logic          accept;
   logic [SW-1:0] stall_cycles_d;
   logic [SW-1:0] stall_cycles_q;

   assign cnt[0]  = '0;
   assign busy[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
         sb_reg_counter #(.LW(LW)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .load     (accept & issue_we & (issue_rd == AW'(gi))),
            .load_val (lat_m1),
            .cnt      (cnt[gi]),
            .nz       (busy[gi])
         );
      end
   endgenerate

   always_comb begin
      lat_eff = LW'(clamp_lat(int'(issue_lat), MAX_LAT));
      lat_m1  = lat_eff - LW'(1);
   end

   // Source checks use the counter values from before this cycle's update,
   // so an instruction that reads and writes the same register never stalls on itself.
   assign rs_wait  = issue_valid & use_rs & (issue_rs != '0) & (cnt[issue_rs] != '0);
   assign rt_wait  = issue_valid & use_rt & (issue_rt != '0) & (cnt[issue_rt] != '0);
   assign waw_wait = issue_valid & issue_we & (issue_rd != '0) & (cnt[issue_rd] > lat_m1);
   assign stall    = rs_wait | rt_wait | waw_wait;
   assign accept   = issue_valid & ~stall & ~kill;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != {SW{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule
